// File: rtl/serial_parallel_rx_pkg.sv
// Constants shared by the serial link transmitter and receiver.
package serial_parallel_rx_pkg;

    localparam logic [7:0] COMMA_K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StAlign  = 2'd1,
        StLocked = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sp_shift_in.sv
// MSB-first serial-in shift register; word_o is the word including the bit being sampled now.
module sp_shift_in #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] sh_q;

    assign word_o = {sh_q[WIDTH-2:0], bit_i};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else begin
            sh_q <= word_o;
        end
    end

endmodule

// File: rtl/serial_parallel_rx.sv
// Serial receiver: hunts for the comma bit-by-bit, confirms byte alignment over several
// commas, then presents recovered non-comma bytes once per byte period.
module serial_parallel_rx
    import serial_parallel_rx_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = COMMA_K28_5,
    parameter int unsigned      LOCK_COUNT = 4
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active,
    output logic             byte_strobe
);

    localparam int unsigned BitW = $clog2(WIDTH);
    localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);

    rx_state_e        state_q;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0]  comma_cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q, active_q, strobe_q;
    logic [WIDTH-1:0] word;
    logic             boundary;
    logic             is_comma;

    sp_shift_in #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk_i  (clk_8f),
        .rst_ni (reset),
        .bit_i  (data_in),
        .word_o (word)
    );

    always_comb begin
        boundary  = (bit_cnt_q == BitW'(WIDTH - 1));
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        is_comma  = (word == COMMA);
    end

    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            state_q     <= StHunt;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            unique case (state_q)
                StHunt: begin
                    if (is_comma) begin
                        bit_cnt_q   <= '0;
                        comma_cnt_q <= CntW'(1);
                        if (LOCK_COUNT <= 1) begin
                            state_q  <= StLocked;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= StAlign;
                        end
                    end
                end
                StAlign: begin
                    bit_cnt_q <= bit_cnt_d;
                    if (boundary) begin
                        if (!is_comma) begin
                            state_q     <= StHunt;
                            comma_cnt_q <= '0;
                        end else if (comma_cnt_q >= CntW'(LOCK_COUNT - 1)) begin
                            state_q     <= StLocked;
                            comma_cnt_q <= CntW'(LOCK_COUNT);
                            active_q    <= 1'b1;
                        end else begin
                            comma_cnt_q <= comma_cnt_q + 1'b1;
                        end
                    end
                end
                StLocked: begin
                    bit_cnt_q <= bit_cnt_d;
                    // Lock is sticky; a comma only clears valid, data_out keeps the last byte.
                    if (boundary) begin
                        strobe_q <= 1'b1;
                        if (is_comma) begin
                            valid_q <= 1'b0;
                        end else begin
                            data_q  <= word;
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StHunt;
            endcase
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign active      = active_q;
    assign byte_strobe = strobe_q;

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Bench for serial_parallel_rx: bit-stream reference model plus a byte scoreboard.
module tb_serial_parallel_rx;

    localparam logic [7:0] BC = 8'hBC;
    localparam int LOCK = 4;

    logic       clk_8f = 1'b0;
    logic       reset  = 1'b0;
    logic       data_in = 1'b1;
    logic [7:0] data_out;
    logic       valid_out, active, byte_strobe;

    serial_parallel_rx dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active      (active),
        .byte_strobe (byte_strobe)
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the bit history since reset and where alignment started.
    bit         hist[$];
    bit         m_aligned = 0;
    int         m_start   = 0;
    int         m_cnt     = 0;
    bit         m_active  = 0;
    logic [7:0] m_data    = '0;
    bit         m_valid   = 0;
    bit         m_strobe  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] window();
        logic [7:0] w;
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = hist.size() - 8 + i;
            w[7-i] = (idx >= 0) ? hist[idx] : 1'b0;
        end
        return w;
    endfunction

    task automatic m_step(input bit b, input bit r);
        logic [7:0] w;
        m_strobe = 0;
        if (!r) begin
            hist.delete();
            m_aligned = 0;
            m_cnt     = 0;
            m_active  = 0;
            m_data    = '0;
            m_valid   = 0;
            return;
        end
        hist.push_back(b);
        w = window();
        if (!m_aligned) begin
            if (w == BC) begin
                m_aligned = 1;
                m_start   = hist.size();
                m_cnt     = 1;
            end
        end else if ((hist.size() - m_start) % 8 == 0) begin
            if (!m_active) begin
                if (w == BC) begin
                    m_cnt++;
                    if (m_cnt >= LOCK) m_active = 1;
                end else begin
                    m_aligned = 0;
                    m_cnt     = 0;
                end
            end else begin
                m_strobe = 1;
                if (w != BC) begin
                    m_data  = w;
                    m_valid = 1;
                end else begin
                    m_valid = 0;
                end
                exp_q.push_back('{data: m_data, valid: m_valid});
            end
        end
    endtask

    // Check what the previous edge produced, then present the next bit.
    task automatic send_bit(input bit b, input bit r);
        @(negedge clk_8f);
        chk("active", 32'(active), 32'(m_active));
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("byte_strobe", 32'(byte_strobe), 32'(m_strobe));
        data_in = b;
        reset   = r;
        m_step(b, r);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected byte.
    always @(negedge clk_8f) begin
        if (byte_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_strobe: got data %0h valid %0b, expected no strobe",
                         data_out, valid_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_data", 32'(data_out), 32'(e.data));
                chk("sb_valid", 32'(valid_out), 32'(e.valid));
                chk("sb_active", 32'(active), 32'd1);
            end
        end
    end

    initial begin
        // 1: reset with data_in high, then idle ones keep active low
        do_reset(3);
        for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b1);
        // 2: aligned commas then a data byte
        for (int i = 0; i < 4; i++) send_byte(BC);
        send_byte(8'h5A);
        send_byte(BC);
        // 3: three junk bits then commas
        do_reset(1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(BC);
        send_byte(8'h5A);
        // 4: broken comma run drops back to hunting
        do_reset(1);
        send_byte(BC);
        send_byte(BC);
        send_byte(8'h12);
        send_byte(BC);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
        // 5: data, comma, data
        do_reset(1);
        for (int i = 0; i < 4; i++) send_byte(BC);
        send_byte(8'h5A);
        send_byte(BC);
        send_byte(8'hC3);
        send_byte(BC);
        // 6: reset mid-byte while locked; four fresh commas needed
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        do_reset(1);
        for (int i = 0; i < 4; i++) send_byte(BC);
        send_byte(8'hA7);
        // Randomized: junk offset, commas, then mixed traffic
        for (int t = 0; t < 4; t++) begin
            do_reset(1 + $urandom_range(0, 2));
            for (int i = 0; i < int'($urandom_range(0, 7)); i++)
                send_bit(1'($urandom_range(0, 1)), 1'b1);
            for (int i = 0; i < 4; i++) send_byte(BC);
            for (int i = 0; i < 30; i++)
                send_byte(($urandom_range(0, 3) == 0) ? BC : 8'($urandom));
        end
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        @(negedge clk_8f);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
